lvds_tx_framer: RTL and testbench
=================================

// Module: lvds_tx_framer
// PURPOSE
//  7:1 FPD-Link framer/serializer for an 18-bit (RGB666) panel, directly downstream of the sync/pattern generator.
//  Runs on the bit clock (7x pixel rate), takes one pixel per 7 cycles, and shifts out 3 data lanes plus 1 clock lane.
//  Issues pix_ce so upstream logic advances exactly once per pixel. Outputs are single-ended; OBUFDS pads sit outside.
// PARAMETERS
//  HS_INVERT    0            1: invert hsync before packing.
//  VS_INVERT    0            1: invert vsync before packing.
//  CLK_PATTERN  7'b1100011   clock-lane word, sent with the same slot order as the data lanes.
// PORTS
//  clk          in   1  bit clock (7x pixel clock); all logic on posedge.
//  rst          in   1  synchronous, active-high reset.
//  tx_en        in   1  0: blank. Packed words are forced to all-zero (DE=HS=VS=0 after inversion is not applied).
//  hsync        in   1  horizontal sync, level as produced upstream.
//  vsync        in   1  vertical sync.
//  de           in   1  data enable.
//  red          in   6  pixel red.
//  green        in   6  pixel green.
//  blue         in   6  pixel blue.
//  pix_ce       out  1  registered strobe, high 1 cycle in 7; upstream updates pixel regs on the same edge.
//  lane0_o      out  1  data lane 0 serial bit.
//  lane1_o      out  1  data lane 1 serial bit.
//  lane2_o      out  1  data lane 2 serial bit.
//  clk_lane_o   out  1  clock lane serial bit.
// BEHAVIOUR
//  - Phase counter p, 3 bits, counts 0..6 and wraps 6->0. Values 7 are unreachable; if p==7 is ever seen, it is forced to 0.
//  - pix_ce is a register, high exactly during the cycles where p==6.
//  - Load edge: the posedge where p==6.
//    - The four 7-bit shift regs load their words from the inputs sampled at that edge.
//    - Upstream regs updating on the same edge are captured at their pre-edge values, so there is no race.
//  - Shift: on every other edge, each shift reg does sh <= {sh[5:0],1'b0}.
//  - Outputs are the register bits sh[6]. Slot k of a word (k=0..6) appears k cycles after the load edge, i.e. word[6-k].
//  - Word packing, bit6..bit0:
//    - lane0 = {G0,R5,R4,R3,R2,R1,R0}
//    - lane1 = {B1,B0,G5,G4,G3,G2,G1}
//    - lane2 = {DE,VS',HS',B5,B4,B3,B2}, where HS'/VS' are the sync bits after the *_INVERT parameters are applied.
//    - clock lane = CLK_PATTERN, reloaded at every load edge.
//  - tx_en is sampled only at load edges. When tx_en=0, the three data words are 0, including DE, HS and VS bits.
//    The clock lane still loads CLK_PATTERN.
//  - Latency: the pixel sampled at load edge E drives slot0 in the cycle after E; its last slot is 6 cycles after that.
//  - Reset (rst=1 at an edge):
//    - p=0, all shift regs 0, pix_ce=0, so all four outputs are 0 in the next cycle.
//    - This applies mid-word as well: the partially sent word is dropped and no resume is attempted.
//  - After reset release:
//    - 7 cycles with all outputs 0 (p=0..6); pix_ce is high in the 7th of these cycles.
//    - The first load happens at the end of that cycle, then a continuous period-7 stream follows.
//  - No backpressure: upstream must present a valid pixel at every pix_ce. Inputs may change freely between load edges.
// STRUCTURE
//  - Shared include lvds_defs.vh holds:
//    - LVDS_WORD_W=7
//    - default CLK_PATTERN
//    - lane bit-map defines (R/G/B/sync slot indices), for reuse by the bench model.
//  - One natural sub-module, lvds_piso7: a 7-bit parallel-load, MSB-first shift reg with load, rst and serial out.
//    It is instantiated 4 times.
//  - The top holds the phase counter, pix_ce, the packer and the tx_en/polarity muxing.
// TESTING
//  1. Reset: rst=1 for 3 cycles, mid-stream.
//     -> all outputs 0 and pix_ce=0 the cycle after the first rst edge.
//     -> after release, exactly 7 zero cycles before the first clock-lane bit.
//  2. Clock lane: tx_en=1, run 70 cycles.
//     -> clk_lane_o repeats 1,1,0,0,0,1,1.
//     -> pix_ce is high once per 7 cycles, aligned with the final 1 of each pattern.
//  3. Pixel packing: R=6'h2A, G=6'h15, B=6'h33, de=1, hs=0, vs=1, defaults.
//     -> lane0 slots 1,1,0,1,0,1,0.
//     -> lane1 slots 1,1,0,1,0,1,0.
//     -> lane2 slots 1,1,0,1,1,0,0.
//  4. Polarity: same pixel with HS_INVERT=1, VS_INVERT=1.
//     -> lane2 slots 1,0,1,1,1,0,0.
//  5. Blank: tx_en=0 at a load edge with a non-zero pixel.
//     -> the next 7 cycles have lanes 0/1/2 = 0 and the clock lane is unchanged.
//  6. Pixel stream with upstream counter on pix_ce, 1280 pixels.
//     -> a scoreboard deserializes the lanes on clock-pattern alignment, and every pixel matches in order.
//     -> nothing is lost or duplicated.

Source files
------------

// File: rtl/lvds_tx_framer_pkg.sv
// Shared constants for the 7:1 FPD-Link framer.
// Word width, default clock pattern and lane slot map.
package lvds_tx_framer_pkg;

  localparam int LVDS_WORD_W = 7;

  localparam logic [LVDS_WORD_W-1:0] LVDS_CLK_PATTERN = 7'b1100011;

  // lane2 bit positions of the control bits
  localparam int L2_DE = 6;
  localparam int L2_VS = 5;
  localparam int L2_HS = 4;

  // lane0 bit position of G0, lane1 bit positions of B1/B0
  localparam int L0_G0 = 6;
  localparam int L1_B1 = 6;
  localparam int L1_B0 = 5;

  // lane0/1/2 word layout, bit6..bit0
  function automatic logic [20:0] pack_words(
    input logic       de,
    input logic       vs,
    input logic       hs,
    input logic [5:0] r,
    input logic [5:0] g,
    input logic [5:0] b
  );
    logic [6:0] w0;
    logic [6:0] w1;
    logic [6:0] w2;
    w0 = {g[0], r};
    w1 = {b[1:0], g[5:1]};
    w2 = {de, vs, hs, b[5:2]};
    return {w2, w1, w0};
  endfunction

endpackage

// File: rtl/lvds_piso7.sv
// 7-bit parallel-load, MSB-first shift register.
// Ports: clk, rst (sync high), load, din[6:0] -> sout = sh[6].
import lvds_tx_framer_pkg::*;

module lvds_piso7 (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [LVDS_WORD_W-1:0] din,
  output logic                   sout
);

  logic [LVDS_WORD_W-1:0] sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh <= '0;
    end else if (load) begin
      sh <= din;
    end else begin
      sh <= {sh[LVDS_WORD_W-2:0], 1'b0};
    end
  end

  assign sout = sh[LVDS_WORD_W-1];

endmodule

// File: rtl/lvds_tx_framer.sv
// 7:1 FPD-Link framer for an RGB666 panel on the bit clock.
// Ports: clk, rst, tx_en, hsync, vsync, de, red/green/blue[5:0] -> pix_ce, lane0_o..lane2_o, clk_lane_o.
import lvds_tx_framer_pkg::*;

module lvds_tx_framer #(
  parameter int                     HS_INVERT   = 0,
  parameter int                     VS_INVERT   = 0,
  parameter logic [LVDS_WORD_W-1:0] CLK_PATTERN = LVDS_CLK_PATTERN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       de,
  input  logic [5:0] red,
  input  logic [5:0] green,
  input  logic [5:0] blue,
  output logic       pix_ce,
  output logic       lane0_o,
  output logic       lane1_o,
  output logic       lane2_o,
  output logic       clk_lane_o
);

  localparam logic HS_X = (HS_INVERT != 0);
  localparam logic VS_X = (VS_INVERT != 0);

  logic [2:0]  p;
  logic        load;
  logic        hs_p;
  logic        vs_p;
  logic [20:0] packed_w;
  logic [6:0]  w0;
  logic [6:0]  w1;
  logic [6:0]  w2;

  // p==7 is unreachable; if ever seen it falls back to 0
  always_ff @(posedge clk) begin
    if (rst) begin
      p      <= 3'd0;
      pix_ce <= 1'b0;
    end else begin
      p      <= (p >= 3'd6) ? 3'd0 : p + 3'd1;
      pix_ce <= (p == 3'd5);
    end
  end

  assign load = (p == 3'd6);

  assign hs_p = hsync ^ HS_X;
  assign vs_p = vsync ^ VS_X;

  assign packed_w = pack_words(de, vs_p, hs_p, red, green, blue);

  // blanking zeroes the whole data word, control bits included
  assign w0 = tx_en ? packed_w[6:0]   : 7'd0;
  assign w1 = tx_en ? packed_w[13:7]  : 7'd0;
  assign w2 = tx_en ? packed_w[20:14] : 7'd0;

  lvds_piso7 u_lane0 (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .din  (w0),
    .sout (lane0_o)
  );

  lvds_piso7 u_lane1 (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .din  (w1),
    .sout (lane1_o)
  );

  lvds_piso7 u_lane2 (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .din  (w2),
    .sout (lane2_o)
  );

  lvds_piso7 u_clk_lane (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .din  (CLK_PATTERN),
    .sout (clk_lane_o)
  );

endmodule

// File: tb/tb_lvds_tx_framer.sv
// Directed bench for lvds_tx_framer: reset, clock lane, packing,
// polarity, blanking and a 1280-pixel deserializing scoreboard.
module tb_lvds_tx_framer;

  logic       clk;
  logic       rst;
  logic       tx_en;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic [5:0] red;
  logic [5:0] green;
  logic [5:0] blue;

  logic pix_ce0, l00, l01, l02, lc0;
  logic pix_ce1, l10, l11, l12, lc1;

  int checks;
  int errors;

  lvds_tx_framer dut0 (
    .clk        (clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .pix_ce     (pix_ce0),
    .lane0_o    (l00),
    .lane1_o    (l01),
    .lane2_o    (l02),
    .clk_lane_o (lc0)
  );

  lvds_tx_framer #(
    .HS_INVERT (1),
    .VS_INVERT (1)
  ) dut1 (
    .clk        (clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .pix_ce     (pix_ce1),
    .lane0_o    (l10),
    .lane1_o    (l11),
    .lane2_o    (l12),
    .clk_lane_o (lc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_pix(
    input logic [5:0] r,
    input logic [5:0] g,
    input logic [5:0] b,
    input logic       d,
    input logic       h,
    input logic       v
  );
    red   = r;
    green = g;
    blue  = b;
    de    = d;
    hsync = h;
    vsync = v;
  endtask

  // leaves us at the negedge inside a p==6 cycle
  task automatic wait_ce(input bit sel);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((sel ? pix_ce1 : pix_ce0) === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_ce: pix_ce got 0 for 20 cycles, required 1");
    end
  endtask

  task automatic test_reset;
    set_pix(6'h3F, 6'h3F, 6'h3F, 1'b1, 1'b1, 1'b1);
    tx_en = 1'b1;
    wait_ce(0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({pix_ce0, l00, l01, l02, lc0} !== 5'b0) begin
      errors++;
      $display("FAIL reset_first: got %b required 00000",
               {pix_ce0, l00, l01, l02, lc0});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if ({l00, l01, l02, lc0} !== 4'b0) begin
        errors++;
        $display("FAIL reset_zero[%0d]: got %b required 0000", i,
                 {l00, l01, l02, lc0});
      end
      checks++;
      if (pix_ce0 !== (i == 6)) begin
        errors++;
        $display("FAIL reset_ce[%0d]: got %b required %b", i,
                 pix_ce0, (i == 6));
      end
    end
    @(negedge clk);
    checks++;
    if (lc0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_clk: got %b required 1", lc0);
    end
  endtask

  task automatic test_clock_lane;
    logic [6:0] pat;
    logic       exp_c;
    pat = 7'b1100011;
    tx_en = 1'b1;
    wait_ce(0);
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      exp_c = pat[6 - (i % 7)];
      checks++;
      if (lc0 !== exp_c || pix_ce0 !== ((i % 7) == 6)) begin
        errors++;
        $display("FAIL clock_lane[%0d]: got clk=%b ce=%b required clk=%b ce=%b",
                 i, lc0, pix_ce0, exp_c, ((i % 7) == 6));
      end
    end
  endtask

  task automatic test_packing;
    logic [6:0] g0, g1, g2;
    tx_en = 1'b1;
    wait_ce(0);
    set_pix(6'h2A, 6'h15, 6'h33, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      g0 = {g0[5:0], l00};
      g1 = {g1[5:0], l01};
      g2 = {g2[5:0], l02};
    end
    checks++;
    if (g0 !== 7'b1101010) begin
      errors++;
      $display("FAIL pack_lane0: got %b required 1101010", g0);
    end
    checks++;
    if (g1 !== 7'b1101010) begin
      errors++;
      $display("FAIL pack_lane1: got %b required 1101010", g1);
    end
    checks++;
    if (g2 !== 7'b1101100) begin
      errors++;
      $display("FAIL pack_lane2: got %b required 1101100", g2);
    end
  endtask

  task automatic test_polarity;
    logic [6:0] g2;
    tx_en = 1'b1;
    wait_ce(1);
    set_pix(6'h2A, 6'h15, 6'h33, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      g2 = {g2[5:0], l12};
    end
    checks++;
    if (g2 !== 7'b1011100) begin
      errors++;
      $display("FAIL polarity_lane2: got %b required 1011100", g2);
    end
  endtask

  task automatic test_blank;
    logic [6:0] gc;
    wait_ce(0);
    set_pix(6'h3F, 6'h2A, 6'h15, 1'b1, 1'b1, 1'b1);
    tx_en = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      gc = {gc[5:0], lc0};
      checks++;
      if ({l00, l01, l02} !== 3'b0) begin
        errors++;
        $display("FAIL blank_data[%0d]: got %b required 000", k,
                 {l00, l01, l02});
      end
    end
    checks++;
    if (gc !== 7'b1100011) begin
      errors++;
      $display("FAIL blank_clk: got %b required 1100011", gc);
    end
    tx_en = 1'b1;
  endtask

  task automatic test_stream;
    logic [6:0]  g0, g1, g2, gc;
    logic [6:0]  e0, e1, e2;
    logic [5:0]  r, g, b;
    logic        d, h, v;
    logic [15:0] nn;
    tx_en = 1'b1;
    wait_ce(0);
    for (int n = 0; n < 1280; n++) begin
      nn = n[15:0];
      r = nn[5:0];
      g = nn[8:3] ^ 6'h2C;
      b = nn[10:5] + 6'd17;
      d = (n % 5) != 0;
      h = nn[2];
      v = nn[4];
      set_pix(r, g, b, d, h, v);
      for (int k = 0; k < 7; k++) begin
        @(negedge clk);
        g0 = {g0[5:0], l00};
        g1 = {g1[5:0], l01};
        g2 = {g2[5:0], l02};
        gc = {gc[5:0], lc0};
      end
      e0 = {g[0], r};
      e1 = {b[1:0], g[5:1]};
      e2 = {d, v, h, b[5:2]};
      checks++;
      if (gc !== 7'b1100011 || pix_ce0 !== 1'b1) begin
        errors++;
        $display("FAIL stream_align[%0d]: got clk=%b ce=%b required 1100011 ce=1",
                 n, gc, pix_ce0);
      end
      checks++;
      if ({g2, g1, g0} !== {e2, e1, e0}) begin
        errors++;
        $display("FAIL stream_pix[%0d]: got %b_%b_%b required %b_%b_%b",
                 n, g2, g1, g0, e2, e1, e0);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    tx_en  = 1'b0;
    set_pix(6'h0, 6'h0, 6'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    test_reset();
    test_clock_lane();
    test_packing();
    test_polarity();
    test_blank();
    test_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
